// File: rtl/mig_ui_arbiter.sv
// mig_ui_arbiter: two-client round-robin sequencer for the MIG 7-series UI port.
// Ports: r0_*/r1_* client req/gnt/rdata, app_* MIG UI, rd_outstanding, err_unexp_rd.
module mig_ui_arbiter #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 256,
  parameter int MASK_W  = 32,
  parameter int MAX_OUT = 16
) (
  input  logic                        ui_clk,
  input  logic                        ui_clk_sync_rst,
  input  logic                        init_calib_complete,
  input  logic                        r0_req,
  input  logic                        r0_cmd,
  input  logic [ADDR_W-1:0]           r0_addr,
  input  logic [DATA_W-1:0]           r0_wdata,
  input  logic                        r1_req,
  input  logic                        r1_cmd,
  input  logic [ADDR_W-1:0]           r1_addr,
  input  logic [DATA_W-1:0]           r1_wdata,
  output logic                        r0_gnt,
  output logic                        r1_gnt,
  output logic [DATA_W-1:0]           r0_rdata,
  output logic [DATA_W-1:0]           r1_rdata,
  output logic                        r0_rvalid,
  output logic                        r1_rvalid,
  output logic                        app_en,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  output logic [2:0]                  app_cmd,
  output logic [ADDR_W-1:0]           app_addr,
  output logic [DATA_W-1:0]           app_wdf_data,
  output logic [MASK_W-1:0]           app_wdf_mask,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic                        app_rd_data_valid,
  input  logic [DATA_W-1:0]           app_rd_data,
  output logic [$clog2(MAX_OUT):0]    rd_outstanding,
  output logic                        err_unexp_rd
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state;
  logic               ptr;
  logic               id_r;
  logic               cmd_done;
  logic               data_done;
  logic [MAX_OUT-1:0] id_mem;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               e0;
  logic               e1;
  logic               w0;
  logic               w1;
  logic               sel_cmd;
  logic               cmd_ok;
  logic               dat_ok;

  assign full  = (count == CW'(MAX_OUT));
  assign empty = (count == '0);

  assign e0 = r0_req & init_calib_complete & (~r0_cmd | ~full);
  assign e1 = r1_req & init_calib_complete & (~r1_cmd | ~full);

  // ptr = 0 favours r0; a lone eligible client wins regardless
  assign w0 = (state == IDLE) & ~ui_clk_sync_rst & e0 & (~e1 | ~ptr);
  assign w1 = (state == IDLE) & ~ui_clk_sync_rst & e1 & (~e0 | ptr);

  assign r0_gnt  = w0;
  assign r1_gnt  = w1;
  assign sel_cmd = w1 ? r1_cmd : r0_cmd;

  assign push   = app_en & app_rdy & app_cmd[0];
  assign pop    = app_rd_data_valid & ~empty;
  assign cmd_ok = cmd_done | (app_en & app_rdy);
  assign dat_ok = data_done | (app_wdf_wren & app_wdf_rdy);

  assign app_wdf_end    = app_wdf_wren;
  assign app_wdf_mask   = '0;
  assign rd_outstanding = count;

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      id_r         <= 1'b0;
      cmd_done     <= 1'b0;
      data_done    <= 1'b0;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_cmd      <= '0;
      app_addr     <= '0;
      app_wdf_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (w0 | w1) begin
            state        <= ISSUE;
            ptr          <= w0;
            id_r         <= w1;
            app_cmd      <= {2'b00, sel_cmd};
            app_addr     <= w1 ? r1_addr : r0_addr;
            app_wdf_data <= w1 ? r1_wdata : r0_wdata;
            app_en       <= 1'b1;
            app_wdf_wren <= ~sel_cmd;
            cmd_done     <= 1'b0;
            // reads carry no data phase
            data_done    <= sel_cmd;
          end
        end
        ISSUE: begin
          if (app_en & app_rdy) begin
            app_en   <= 1'b0;
            cmd_done <= 1'b1;
          end
          if (app_wdf_wren & app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            data_done    <= 1'b1;
          end
          if (cmd_ok & dat_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      id_mem       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      r0_rvalid    <= 1'b0;
      r1_rvalid    <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      err_unexp_rd <= 1'b0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (push) begin
        id_mem[wr_ptr] <= id_r;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (id_mem[rd_ptr]) begin
          r1_rvalid <= 1'b1;
          r1_rdata  <= app_rd_data;
        end else begin
          r0_rvalid <= 1'b1;
          r0_rdata  <= app_rd_data;
        end
      end
      // beat with no owner is dropped
      if (app_rd_data_valid & empty) begin
        err_unexp_rd <= 1'b1;
      end
      if (push & ~pop) begin
        count <= count + CW'(1);
      end else if (pop & ~push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// tb_mig_ui_arbiter: directed stimulus with a transaction-level model
// checked every cycle, plus hand-computed literal checks.
module tb_mig_ui_arbiter;
  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int MO = 16;

  logic          ui_clk = 1'b0;
  logic          rst = 1'b0;
  logic          calib = 1'b0;
  logic          r0_req = 0, r0_cmd = 0, r1_req = 0, r1_cmd = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_rdy = 1, app_wdf_rdy = 1, app_rd_data_valid = 0;
  logic [DW-1:0] app_rd_data = '0;
  logic [4:0]    rd_outstanding;
  logic          err_unexp_rd;

  int checks = 0;
  int fails = 0;

  always #5 ui_clk = ~ui_clk;

  mig_ui_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .MAX_OUT(MO)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .rd_outstanding(rd_outstanding), .err_unexp_rd(err_unexp_rd)
  );

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit            m_busy, m_cp, m_dp, m_cmd, m_id, m_rr, m_err;
  bit            m_rv0, m_rv1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd0, m_rd1;
  int            m_q[$];

  always @(negedge ui_clk) begin : model
    bit e0, e1, g0, g1;
    int id;
    if (rst) begin
      m_busy = 0; m_cp = 0; m_dp = 0; m_cmd = 0; m_id = 0; m_rr = 0;
      m_err = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
      m_q.delete();
    end
    e0 = r0_req && calib && (!r0_cmd || m_q.size() < MO);
    e1 = r1_req && calib && (!r1_cmd || m_q.size() < MO);
    g0 = !rst && !m_busy && e0 && (!e1 || m_rr == 0);
    g1 = !rst && !m_busy && e1 && (!e0 || m_rr == 1);
    check("m_r0_gnt", r0_gnt, g0);
    check("m_r1_gnt", r1_gnt, g1);
    check("m_app_en", app_en, m_cp);
    check("m_wdf_wren", app_wdf_wren, m_dp);
    check("m_wdf_end", app_wdf_end, m_dp);
    check("m_wdf_mask", app_wdf_mask, 0);
    check("m_r0_rvalid", r0_rvalid, m_rv0);
    check("m_r1_rvalid", r1_rvalid, m_rv1);
    check("m_r0_rdata", r0_rdata, m_rd0);
    check("m_r1_rdata", r1_rdata, m_rd1);
    check("m_outstanding", rd_outstanding, m_q.size());
    check("m_err", err_unexp_rd, m_err);
    if (m_busy) begin
      check("m_app_cmd", app_cmd, {2'b00, m_cmd});
      check("m_app_addr", app_addr, m_addr);
      if (!m_cmd) check("m_wdf_data", app_wdf_data, m_data);
    end
    m_rv0 = 0;
    m_rv1 = 0;
    if (!rst) begin
      if (app_rd_data_valid) begin
        if (m_q.size() == 0) m_err = 1;
        else begin
          id = m_q.pop_front();
          if (id == 0) begin m_rv0 = 1; m_rd0 = app_rd_data; end
          else begin m_rv1 = 1; m_rd1 = app_rd_data; end
        end
      end
      if (m_busy) begin
        if (m_cp && app_rdy) begin
          m_cp = 0;
          if (m_cmd) m_q.push_back(int'(m_id));
        end
        if (m_dp && app_wdf_rdy) m_dp = 0;
        if (!m_cp && !m_dp) m_busy = 0;
      end else if (g0 || g1) begin
        m_busy = 1;
        m_id   = g1;
        m_cmd  = g1 ? r1_cmd : r0_cmd;
        m_addr = g1 ? r1_addr : r0_addr;
        m_data = g1 ? r1_wdata : r0_wdata;
        m_cp   = 1;
        m_dp   = !m_cmd;
        m_rr   = g0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic mid();
    #6;
  endtask

  task automatic issue(input int id, input logic c, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bit got = 0;
    if (id == 0) begin
      r0_req = 1; r0_cmd = c; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = 1; r1_cmd = c; r1_addr = a; r1_wdata = d;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      mid();
      got = (id == 0) ? r0_gnt : r1_gnt;
      cyc();
    end
    if (id == 0) r0_req = 0;
    else r1_req = 0;
    check("issue_gnt", got, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit g0, g1;
    int n, expid;
    #1 rst = 1;
    cyc(); cyc();
    mid();
    check("rst_app_en", app_en, 0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_err", err_unexp_rd, 0);
    check("rst_r0_rvalid", r0_rvalid, 0);
    cyc();
    rst = 0;

    // no grant while calibration incomplete
    r0_req = 1; r0_cmd = 0; r0_addr = 29'h10; r0_wdata = 256'hA5;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("calib_no_gnt", r0_gnt, 0);
      cyc();
    end

    // single write
    calib = 1;
    mid();
    check("wr_gnt", r0_gnt, 1);
    cyc();
    r0_req = 0;
    mid();
    check("wr_app_en", app_en, 1);
    check("wr_wren", app_wdf_wren, 1);
    check("wr_cmd", app_cmd, 0);
    check("wr_addr", app_addr, 29'h10);
    check("wr_data", app_wdf_data, 256'hA5);
    cyc();
    mid();
    check("wr_idle_en", app_en, 0);

    // split handshake
    cyc();
    app_rdy = 0;
    r1_req = 1; r1_cmd = 0; r1_addr = 29'h20; r1_wdata = 256'h5A;
    mid();
    check("split_gnt", r1_gnt, 1);
    cyc();
    r1_req = 0;
    r0_req = 1; r0_cmd = 0; r0_addr = 29'h30; r0_wdata = 256'h3C;
    mid();
    check("split_c1_en", app_en, 1);
    check("split_c1_wren", app_wdf_wren, 1);
    cyc();
    mid();
    check("split_c2_en", app_en, 1);
    check("split_c2_wren", app_wdf_wren, 0);
    check("split_c2_gnt", r0_gnt, 0);
    cyc();
    mid();
    check("split_c3_en", app_en, 1);
    cyc();
    app_rdy = 1;
    mid();
    check("split_c4_en", app_en, 1);
    check("split_c4_gnt", r0_gnt, 0);
    cyc();
    mid();
    check("split_c5_en", app_en, 0);
    check("split_c5_gnt", r0_gnt, 1);
    cyc();
    r0_req = 0;
    cyc();

    // round robin: last grant was r0, so r1 goes first
    r0_req = 1; r0_cmd = 0; r0_addr = 29'h100; r0_wdata = 256'h1;
    r1_req = 1; r1_cmd = 0; r1_addr = 29'h101; r1_wdata = 256'h2;
    n = 0;
    expid = 1;
    for (int i = 0; i < 100 && n < 20; i++) begin
      mid();
      if (r0_gnt || r1_gnt) begin
        check("rr_order", r1_gnt, expid[0]);
        expid ^= 1;
        n++;
      end
      cyc();
    end
    r0_req = 0;
    r1_req = 0;
    check("rr_count", n, 20);
    cyc(); cyc();

    // read routing
    issue(0, 1, 29'h40, '0);
    issue(1, 1, 29'h41, '0);
    issue(0, 1, 29'h42, '0);
    cyc();
    mid();
    check("rd_out3", rd_outstanding, 3);
    cyc();
    app_rd_data_valid = 1; app_rd_data = 256'h1;
    cyc();
    app_rd_data = 256'h2;
    mid();
    check("rd1_r0_rvalid", r0_rvalid, 1);
    check("rd1_r0_rdata", r0_rdata, 256'h1);
    check("rd1_r1_rvalid", r1_rvalid, 0);
    cyc();
    app_rd_data = 256'h3;
    mid();
    check("rd2_r1_rvalid", r1_rvalid, 1);
    check("rd2_r1_rdata", r1_rdata, 256'h2);
    check("rd2_r0_rvalid", r0_rvalid, 0);
    cyc();
    app_rd_data_valid = 0;
    mid();
    check("rd3_r0_rvalid", r0_rvalid, 1);
    check("rd3_r0_rdata", r0_rdata, 256'h3);
    check("rd3_r1_hold", r1_rdata, 256'h2);
    cyc();
    mid();
    check("rd_out0", rd_outstanding, 0);

    // FIFO full
    cyc();
    for (int k = 0; k < 16; k++) issue(k % 2, 1, 29'(32'h200 + k), '0);
    cyc();
    mid();
    check("full_out16", rd_outstanding, 16);
    cyc();
    r0_req = 1; r0_cmd = 1; r0_addr = 29'h300;
    r1_req = 1; r1_cmd = 0; r1_addr = 29'h301; r1_wdata = 256'hBEEF;
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      g0 |= r0_gnt;
      if (r1_gnt) g1 = 1;
      cyc();
      if (g1) r1_req = 0;
    end
    check("full_rd_blocked", g0, 0);
    check("full_wr_granted", g1, 1);
    app_rd_data_valid = 1; app_rd_data = 256'h77;
    cyc();
    app_rd_data_valid = 0;
    mid();
    check("full_ret_rvalid", r0_rvalid, 1);
    check("full_ret_rdata", r0_rdata, 256'h77);
    g0 = r0_gnt;
    cyc();
    for (int i = 0; i < 6 && !g0; i++) begin
      mid();
      g0 = r0_gnt;
      cyc();
    end
    r0_req = 0;
    check("full_rd_after_pop", g0, 1);
    cyc();
    for (int k = 0; k < 16; k++) begin
      app_rd_data_valid = 1;
      app_rd_data = 256'(32'h1000 + k);
      cyc();
    end
    app_rd_data_valid = 0;
    cyc();
    mid();
    check("drain_out0", rd_outstanding, 0);

    // unexpected read data
    cyc();
    app_rd_data_valid = 1; app_rd_data = 256'hDEAD;
    cyc();
    app_rd_data_valid = 0;
    mid();
    check("unexp_err", err_unexp_rd, 1);
    check("unexp_r0_rvalid", r0_rvalid, 0);
    check("unexp_r1_rvalid", r1_rvalid, 0);

    // reset during ISSUE
    cyc();
    issue(0, 1, 29'h500, '0);
    cyc();
    app_rdy = 0;
    issue(1, 0, 29'h501, 256'h55);
    mid();
    check("pre_rst_en", app_en, 1);
    check("pre_rst_out", rd_outstanding, 1);
    #1 rst = 1;
    #1;
    check("arst_app_en", app_en, 0);
    check("arst_wren", app_wdf_wren, 0);
    check("arst_addr", app_addr, 0);
    check("arst_out", rd_outstanding, 0);
    check("arst_err", err_unexp_rd, 0);
    cyc(); cyc();
    rst = 0;
    app_rdy = 1;
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
